// File: rtl/bus_pkg.sv
// Shared types for the bus master controller.
// Command record, FSM states and bus widths.
package bus_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    WAIT_RD,
    RELEASE
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Command, arbiter, peripheral and response signals.
// master = controller view, slave = environment view.
interface bus_master_ctrl_if
  import bus_pkg::*;
  ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              req;
  logic              grant;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready,
    output req,
    input  grant,
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready,
    input  req,
    output grant,
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

endinterface

// File: rtl/cmd_fifo.sv
// Command queue feeding the bus master FSM.
// Power-of-two depth; pointers wrap naturally.
module cmd_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cmd_t           mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // a push while full is dropped even if a pop frees a slot
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// Queued bus master: request/grant arbitration,
// single-beat read/write strobes, registered response.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int GRANT_TIMEOUT = 15,
  parameter int READ_LAT      = 1
) (
  input logic               clk,
  input logic               rst,
  bus_master_ctrl_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int LW = $clog2(READ_LAT + 1);

  state_t          state;
  state_t          state_nx;

  cmd_t            cur;
  cmd_t            fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;

  logic [TW-1:0]   wait_cnt;
  logic [TW-1:0]   wait_nx;
  logic [LW-1:0]   lat_cnt;
  logic [LW-1:0]   lat_nx;

  logic              req_q;
  logic              req_nx;
  logic              wr_q;
  logic              wr_nx;
  logic              rd_q;
  logic              rd_nx;
  logic              rv_q;
  logic              rv_nx;
  logic              re_q;
  logic              re_nx;
  logic [DATA_W-1:0] rdat_q;
  logic [DATA_W-1:0] rdat_nx;

  assign push = bus.cmd_valid &&
                (fifo_count != CW'(FIFO_DEPTH));

  assign bus.cmd_ready = ~fifo_full;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.cmd_write,
             bus.cmd_addr,
             bus.cmd_wdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    lat_nx   = lat_cnt;
    pop      = 1'b0;
    req_nx   = 1'b0;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    rv_nx    = 1'b0;
    re_nx    = 1'b0;
    rdat_nx  = '0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          wait_nx  = '0;
          lat_nx   = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        req_nx = 1'b1;
        // grant only counts once the arbiter can see req
        if (req_q) begin
          if (bus.grant) begin
            state_nx = XFER;
            wr_nx    = cur.write;
            rd_nx    = ~cur.write;
          end else if (wait_cnt ==
                       TW'(GRANT_TIMEOUT - 1)) begin
            state_nx = RELEASE;
            req_nx   = 1'b0;
            rv_nx    = 1'b1;
            re_nx    = 1'b1;
          end else begin
            wait_nx = wait_cnt + 1'b1;
          end
        end
      end
      XFER: begin
        if (!bus.grant) begin
          state_nx = RELEASE;
          rv_nx    = 1'b1;
          re_nx    = 1'b1;
        end else if (cur.write) begin
          state_nx = RELEASE;
          rv_nx    = 1'b1;
        end else begin
          state_nx = WAIT_RD;
          req_nx   = 1'b1;
          lat_nx   = '0;
        end
      end
      WAIT_RD: begin
        if (!bus.grant) begin
          state_nx = RELEASE;
          rv_nx    = 1'b1;
          re_nx    = 1'b1;
        end else if (lat_cnt ==
                     LW'(READ_LAT - 1)) begin
          state_nx = RELEASE;
          rv_nx    = 1'b1;
          rdat_nx  = bus.rdata;
        end else begin
          req_nx = 1'b1;
          lat_nx = lat_cnt + 1'b1;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lat_cnt  <= '0;
      cur      <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      lat_cnt  <= lat_nx;
      if (pop) begin
        cur <= fifo_dout;
      end
      req_q    <= req_nx;
      wr_q     <= wr_nx;
      rd_q     <= rd_nx;
      rv_q     <= rv_nx;
      re_q     <= re_nx;
      rdat_q   <= rdat_nx;
    end
  end

  assign bus.req       = req_q;
  assign bus.wr_en     = wr_q;
  assign bus.rd_en     = rd_q;
  assign bus.addr      = cur.addr;
  assign bus.wdata     = cur.wdata;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_err   = re_q;
  assign bus.rsp_data  = rdat_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl with a
// 4-register peripheral and a response log.
module tb_bus_master_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_master_ctrl_if bus ();

  bus_master_ctrl #(
    .FIFO_DEPTH    (4),
    .GRANT_TIMEOUT (15),
    .READ_LAT      (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [3:0] regs [4];
  logic [3:0] rq_data [$];
  logic       rq_err [$];

  // peripheral: reset preload, one-cycle read latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      regs[0]   <= 4'h0;
      regs[1]   <= 4'hC;
      regs[2]   <= 4'h6;
      regs[3]   <= 4'h9;
      bus.rdata <= 4'h0;
    end else begin
      if (bus.wr_en) regs[bus.addr] <= bus.wdata;
      if (bus.rd_en) bus.rdata <= regs[bus.addr];
    end
  end

  always @(posedge clk) begin
    if (bus.wr_en) wr_cnt++;
    if (bus.rd_en) rd_cnt++;
    if (bus.rsp_valid) begin
      rq_data.push_back(bus.rsp_data);
      rq_err.push_back(bus.rsp_err);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w,
                      input logic [1:0] a,
                      input logic [3:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound,
                          output logic seen,
                          output logic [3:0] data,
                          output logic err);
    seen = 1'b0;
    data = 4'h0;
    err  = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (bus.rsp_valid) begin
        seen = 1'b1;
        data = bus.rsp_data;
        err  = bus.rsp_err;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [3:0] data;
    logic       err;
    int         hicnt;
    int         rd0;
    int         wr0;
    logic [3:0] ff_exp [5];

    ff_exp = '{4'h0, 4'hC, 4'h6, 4'h9, 4'h3};

    rst           = 1'b1;
    bus.grant     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 2'b00;
    bus.cmd_wdata = 4'h0;
    tick();
    tick();
    check("rst_ctl",
          {bus.req, bus.wr_en, bus.rd_en,
           bus.rsp_valid, bus.rsp_err}, 0);
    check("rst_dat",
          {bus.addr, bus.wdata, bus.rsp_data}, 0);
    check("rst_rdy", bus.cmd_ready, 1);
    rst = 1'b0;
    tick();
    tick();

    // write path, grant tied high
    bus.grant = 1'b1;
    push(1'b1, 2'd0, 4'hA);
    check("wr_req_e0", bus.req, 0);
    tick();
    check("wr_req_e1", bus.req, 0);
    check("wr_addr_wd", {bus.addr, bus.wdata}, 6'h0A);
    tick();
    check("wr_req_e2", {bus.req, bus.wr_en}, 2'b10);
    tick();
    check("wr_strobe",
          {bus.req, bus.wr_en, bus.rd_en}, 3'b110);
    check("wr_bus", {bus.addr, bus.wdata}, 6'h0A);
    tick();
    check("wr_rsp",
          {bus.req, bus.wr_en,
           bus.rsp_valid, bus.rsp_err}, 4'b0010);
    check("wr_rsp_dat", bus.rsp_data, 0);
    tick();
    check("wr_gap", {bus.req, bus.rsp_valid}, 0);
    check("wr_reg0", regs[0], 4'hA);
    check("wr_cnt", wr_cnt, 1);

    // read path
    push(1'b0, 2'd1, 4'h0);
    tick();
    tick();
    tick();
    check("rd_strobe", {bus.rd_en, bus.wr_en}, 2'b10);
    check("rd_addr", bus.addr, 1);
    tick();
    check("rd_wait", {bus.req, bus.rd_en}, 2'b10);
    tick();
    check("rd_rsp",
          {bus.req, bus.rsp_valid, bus.rsp_err}, 3'b010);
    check("rd_data", bus.rsp_data, 4'hC);
    check("rd_cnt", rd_cnt, 1);

    // grant timeout
    tick();
    bus.grant = 1'b0;
    push(1'b1, 2'd2, 4'h5);
    tick();
    tick();
    hicnt = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        data = bus.rsp_data;
        err  = bus.rsp_err;
      end else begin
        if (bus.req) hicnt++;
        tick();
      end
    end
    check("to_seen", seen, 1);
    check("to_req_cycles", hicnt, 15);
    check("to_err", err, 1);
    check("to_data", data, 0);
    check("to_no_wr", wr_cnt, 1);

    bus.grant = 1'b1;
    push(1'b0, 2'd1, 4'h0);
    wait_rsp(20, seen, data, err);
    check("after_to",
          {seen, err, data}, {1'b1, 1'b0, 4'hC});

    // FIFO full: dummy occupies the FSM first
    tick();
    tick();
    bus.grant = 1'b0;
    rq_data.delete();
    rq_err.delete();
    push(1'b1, 2'd0, 4'h3);
    push(1'b0, 2'd1, 4'h0);
    check("ff_rdy1", bus.cmd_ready, 1);
    push(1'b0, 2'd2, 4'h0);
    check("ff_rdy2", bus.cmd_ready, 1);
    push(1'b0, 2'd3, 4'h0);
    check("ff_rdy3", bus.cmd_ready, 1);
    push(1'b0, 2'd0, 4'h0);
    check("ff_rdy4", bus.cmd_ready, 0);
    push(1'b1, 2'd1, 4'hF);
    check("ff_rdy5", bus.cmd_ready, 0);
    bus.grant = 1'b1;
    for (int i = 0; i < 120 && rq_data.size() < 5; i++)
      tick();
    repeat (20) tick();
    check("ff_n_rsp", rq_data.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ff_rsp%0d", i),
            (i < rq_data.size()) ?
              {27'd0, rq_err[i], rq_data[i]} :
              32'h1F,
            {28'd0, ff_exp[i]});
    end
    check("ff_drop", regs[1], 4'hC);
    check("ff_rdy_end", bus.cmd_ready, 1);

    // grant lost during WAIT_RD
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    push(1'b0, 2'd2, 4'h0);
    tick();
    tick();
    tick();
    check("pre_rd", bus.rd_en, 1);
    tick();
    check("pre_wait", {bus.req, bus.rd_en}, 2'b10);
    bus.grant = 1'b0;
    tick();
    check("pre_rsp",
          {bus.rsp_valid, bus.rsp_err, bus.rsp_data},
          6'b110000);
    repeat (5) tick();
    check("pre_strobes", rd_cnt - rd0, 1);
    check("pre_no_wr", wr_cnt - wr0, 0);
    check("pre_idle",
          {bus.req, bus.wr_en, bus.rd_en}, 0);

    // reset in the middle of XFER
    bus.grant = 1'b1;
    rq_data.delete();
    rq_err.delete();
    wr0 = wr_cnt;
    push(1'b1, 2'd3, 4'h7);
    push(1'b1, 2'd3, 4'h8);
    tick();
    tick();
    check("rx_xfer", bus.wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rx_ctl",
          {bus.req, bus.wr_en, bus.rd_en,
           bus.rsp_valid, bus.rsp_err}, 0);
    check("rx_dat", {bus.addr, bus.wdata}, 0);
    check("rx_rdy", bus.cmd_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("rx_no_rsp", rq_data.size(), 0);
    check("rx_no_wr", wr_cnt - wr0, 0);
    check("rx_empty", {bus.req, regs[3]}, 5'h09);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
